// File: rtl/sqrt_otfc_fgen.sv
// On-the-fly root conversion and addend generation for a digit-recurrence square root.
// Keeps U (root) and UM (root minus one ulp) and derives the addend F for the presented digit.
module sqrt_otfc_fgen #(
    parameter int DIVb  = 26,
    parameter int RADIX = 4,
    localparam int K    = $clog2(RADIX),
    localparam int DW   = 2 * K,
    localparam int ITER = DIVb / K,
    localparam int W    = DIVb + 4,
    localparam int M    = (RADIX == 4) ? 3 : 2,
    localparam int JW   = $clog2(ITER + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [W-1:0]  U0,
    input  logic [W-1:0]  UM0,
    input  logic          flush,
    input  logic          digit_valid,
    input  logic [DW-1:0] udigit,
    output logic          ready,
    output logic [W-1:0]  F,
    output logic [W-1:0]  U,
    output logic [W-1:0]  UM,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, BUSY, FIN} state_t;

    state_t        state;
    logic [W-1:0]  c;
    logic [JW-1:0] j;

    logic          busy, legal;
    logic          pos2, pos1, neg1, neg2;
    logic [W-1:0]  w, delta, nxt_u;

    assign busy  = (state == BUSY);
    assign legal = $onehot0(udigit);
    // done and a newly accepted start never share a cycle
    assign ready = (state != BUSY) && !done;

    generate
        if (RADIX == 4) begin : g_r4
            assign pos2 = legal & udigit[3];
            assign pos1 = legal & udigit[2];
            assign neg1 = legal & udigit[1];
            assign neg2 = legal & udigit[0];
        end else begin : g_r2
            assign pos2 = 1'b0;
            assign pos1 = legal & udigit[1];
            assign neg1 = legal & udigit[0];
            assign neg2 = 1'b0;
        end
    endgenerate

    // weight of the current digit position: 2^-(K*(j+1)) in Q4.DIVb
    assign w = W'(1) << (DIVb - K * (int'(j) + 1));

    always_comb begin
        delta = '0;
        if (pos2)      delta = w << 1;
        else if (pos1) delta = w;
        else if (neg1) delta = -w;
        else if (neg2) delta = -(w << 1);
    end

    assign nxt_u = U + delta;

    always_comb begin
        F = '0;
        if (busy) begin
            if (pos2)      F = (~U << 2) & (c << 2);
            else if (pos1) F = ~(U << 1) & c;
            else if (neg1) F = (UM << 1) | (c & ~(c << M));
            else if (neg2) F = (UM << 2) | ((c << 2) & ~(c << (M + 1)));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            U     <= '0;
            UM    <= '0;
            c     <= '0;
            j     <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, FIN: begin
                        if (start && ready) begin
                            U     <= U0;
                            UM    <= UM0;
                            c     <= {4'b1111, {DIVb{1'b0}}};
                            j     <= '0;
                            err   <= 1'b0;
                            state <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (digit_valid) begin
                            U  <= nxt_u;
                            UM <= nxt_u - w;
                            c  <= $unsigned($signed(c) >>> K);
                            j  <= j + 1'b1;
                            if (!legal) err <= 1'b1;
                            if (j == JW'(ITER - 1)) begin
                                state <= FIN;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sqrt_otfc_fgen.sv
// Directed bench for sqrt_otfc_fgen: radix-4 and radix-2 instances, DIVb=8.
module tb_sqrt_otfc_fgen;

    localparam logic [3:0] P2 = 4'b1000, P1 = 4'b0100, N1 = 4'b0010, N2 = 4'b0001, Z = 4'b0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          cmp = 0;
    int          mis = 0;

    logic        start4 = 0, flush4 = 0, dv4 = 0;
    logic [11:0] u0_4 = 0, um0_4 = 0;
    logic [3:0]  ud4 = 0;
    logic        ready4, done4, err4;
    logic [11:0] f4, u4, um4;

    logic        start2 = 0, flush2 = 0, dv2 = 0;
    logic [11:0] u0_2 = 0, um0_2 = 0;
    logic [1:0]  ud2 = 0;
    logic        ready2, done2, err2;
    logic [11:0] f2, u2, um2;

    sqrt_otfc_fgen #(.DIVb(8), .RADIX(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start4), .U0(u0_4), .UM0(um0_4),
        .flush(flush4), .digit_valid(dv4), .udigit(ud4), .ready(ready4),
        .F(f4), .U(u4), .UM(um4), .done(done4), .err(err4));

    sqrt_otfc_fgen #(.DIVb(8), .RADIX(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .U0(u0_2), .UM0(um0_2),
        .flush(flush2), .digit_valid(dv2), .udigit(ud2), .ready(ready2),
        .F(f2), .U(u2), .UM(um2), .done(done2), .err(err2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_r4(input logic [11:0] a, input logic [11:0] b);
        u0_4 = a; um0_4 = b; start4 = 1; dv4 = 0; ud4 = Z;
        tick();
        start4 = 0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        #2;
        cmp++; if (ready4 !== 1'b1) begin mis++; $display("FAIL reset_ready got %b want 1", ready4); end
        cmp++; if ({u4, um4, f4} !== 36'h0) begin mis++; $display("FAIL reset_u_um_f got %h %h %h want 0", u4, um4, f4); end
        cmp++; if ({done4, err4} !== 2'b00) begin mis++; $display("FAIL reset_done_err got %b%b want 00", done4, err4); end
        tick();
        reset_n = 1;
    endtask

    task automatic test_first_digit();
        start_r4(12'h100, 12'h0C0);
        cmp++; if (ready4 !== 1'b0 || u4 !== 12'h100 || um4 !== 12'h0C0) begin mis++; $display("FAIL load got rdy=%b U=%h UM=%h want 0 100 0c0", ready4, u4, um4); end
        dv4 = 1; ud4 = P1; #1;
        cmp++; if (f4 !== 12'hD00) begin mis++; $display("FAIL f_plus1 got %h want d00", f4); end
        tick();
        dv4 = 0;
        cmp++; if (u4 !== 12'h140 || um4 !== 12'h100) begin mis++; $display("FAIL upd_plus1 got %h %h want 140 100", u4, um4); end
        cmp++; if (dut.c !== 12'hFC0) begin mis++; $display("FAIL c_shift got %h want fc0", dut.c); end
        flush4 = 1; tick(); flush4 = 0;
    endtask

    task automatic test_sequence();
        start_r4(12'h100, 12'h0C0);
        dv4 = 1; ud4 = P1; tick();
        ud4 = N1; #1;
        cmp++; if (f4 !== 12'h3C0) begin mis++; $display("FAIL f_minus1 got %h want 3c0", f4); end
        tick();
        ud4 = P2; #1;
        cmp++; if (f4 !== 12'hB00) begin mis++; $display("FAIL f_plus2 got %h want b00", f4); end
        tick();
        ud4 = Z; #1;
        cmp++; if (f4 !== 12'h000 || done4 !== 1'b0) begin mis++; $display("FAIL f_zero_pre_done got %h %b want 000 0", f4, done4); end
        tick();
        dv4 = 0;
        cmp++; if (done4 !== 1'b1) begin mis++; $display("FAIL done_pulse got %b want 1", done4); end
        cmp++; if (u4 !== 12'h138 || um4 !== 12'h137) begin mis++; $display("FAIL seq_result got %h %h want 138 137", u4, um4); end
        tick();
        cmp++; if (done4 !== 1'b0 || ready4 !== 1'b1) begin mis++; $display("FAIL done_clear got done=%b rdy=%b want 0 1", done4, ready4); end
        cmp++; if (u4 !== 12'h138 || um4 !== 12'h137) begin mis++; $display("FAIL hold_after_done got %h %h want 138 137", u4, um4); end
    endtask

    task automatic test_stall();
        start_r4(12'h100, 12'h0C0);
        dv4 = 1; ud4 = N2; #1;
        cmp++; if (f4 !== 12'hF00) begin mis++; $display("FAIL f_minus2 got %h want f00", f4); end
        tick();
        cmp++; if (u4 !== 12'h080 || um4 !== 12'h040) begin mis++; $display("FAIL upd_minus2 got %h %h want 080 040", u4, um4); end
        dv4 = 0; ud4 = P1;
        for (int s = 0; s < 3; s++) begin
            #1;
            cmp++; if (f4 !== 12'hEC0) begin mis++; $display("FAIL f_stall got %h want ec0", f4); end
            tick();
            cmp++; if (u4 !== 12'h080 || um4 !== 12'h040 || dut.c !== 12'hFC0 || dut.j !== 3'd1 || done4 !== 1'b0)
                begin mis++; $display("FAIL stall_hold got U=%h UM=%h C=%h j=%0d done=%b", u4, um4, dut.c, dut.j, done4); end
        end
        dv4 = 1; ud4 = Z;
        for (int s = 0; s < 3; s++) begin
            cmp++; if (done4 !== 1'b0) begin mis++; $display("FAIL done_early got %b want 0", done4); end
            tick();
        end
        dv4 = 0;
        cmp++; if (done4 !== 1'b1 || u4 !== 12'h080 || um4 !== 12'h07F) begin mis++; $display("FAIL stall_done got done=%b U=%h UM=%h want 1 080 07f", done4, u4, um4); end
        tick();
    endtask

    task automatic test_illegal_digit();
        start_r4(12'h100, 12'h0C0);
        dv4 = 0; ud4 = 4'b0110; tick();
        cmp++; if (err4 !== 1'b0 || u4 !== 12'h100) begin mis++; $display("FAIL err_no_valid got err=%b U=%h want 0 100", err4, u4); end
        dv4 = 1; #1;
        cmp++; if (f4 !== 12'h000) begin mis++; $display("FAIL f_illegal got %h want 000", f4); end
        tick();
        dv4 = 0; ud4 = Z;
        cmp++; if (err4 !== 1'b1 || u4 !== 12'h100 || um4 !== 12'h0C0) begin mis++; $display("FAIL err_set got err=%b U=%h UM=%h want 1 100 0c0", err4, u4, um4); end
        flush4 = 1; tick(); flush4 = 0;
        cmp++; if (err4 !== 1'b1 || ready4 !== 1'b1) begin mis++; $display("FAIL err_sticky got err=%b rdy=%b want 1 1", err4, ready4); end
        start_r4(12'h100, 12'h0C0);
        cmp++; if (err4 !== 1'b0) begin mis++; $display("FAIL err_clear got %b want 0", err4); end
        flush4 = 1; tick(); flush4 = 0;
    endtask

    task automatic test_flush_reset();
        start_r4(12'h100, 12'h0C0);
        flush4 = 1; start4 = 1; u0_4 = 12'h200; dv4 = 1; ud4 = P1;
        tick();
        flush4 = 0; start4 = 0; dv4 = 0;
        cmp++; if (ready4 !== 1'b1 || done4 !== 1'b0 || u4 !== 12'h100 || f4 !== 12'h000)
            begin mis++; $display("FAIL flush_prio got rdy=%b done=%b U=%h F=%h want 1 0 100 000", ready4, done4, u4, f4); end
        tick();
        cmp++; if (done4 !== 1'b0) begin mis++; $display("FAIL flush_no_done got %b want 0", done4); end
        start_r4(12'h100, 12'h0C0);
        dv4 = 1; ud4 = P1; tick();
        #2 reset_n = 0; #1;
        cmp++; if (u4 !== 12'h0 || um4 !== 12'h0 || f4 !== 12'h0 || ready4 !== 1'b1 || done4 !== 1'b0 || err4 !== 1'b0)
            begin mis++; $display("FAIL async_reset got U=%h UM=%h F=%h rdy=%b done=%b err=%b", u4, um4, f4, ready4, done4, err4); end
        dv4 = 0; ud4 = Z;
        tick();
        reset_n = 1;
        tick();
        cmp++; if (done4 !== 1'b0 || ready4 !== 1'b1) begin mis++; $display("FAIL reset_no_done got done=%b rdy=%b", done4, ready4); end
    endtask

    task automatic test_radix2();
        u0_2 = 12'h100; um0_2 = 12'h0C0; start2 = 1; tick(); start2 = 0;
        dv2 = 1; ud2 = 2'b10; #1;
        cmp++; if (f2 !== 12'hD00) begin mis++; $display("FAIL r2_f_plus1 got %h want d00", f2); end
        tick();
        cmp++; if (u2 !== 12'h180 || um2 !== 12'h100) begin mis++; $display("FAIL r2_upd got %h %h want 180 100", u2, um2); end
        ud2 = 2'b00;
        for (int s = 0; s < 7; s++) begin
            cmp++; if (done2 !== 1'b0) begin mis++; $display("FAIL r2_done_early got %b at digit %0d", done2, s + 1); end
            tick();
        end
        dv2 = 0;
        cmp++; if (done2 !== 1'b1 || u2 !== 12'h180 || um2 !== 12'h17F) begin mis++; $display("FAIL r2_done got done=%b U=%h UM=%h want 1 180 17f", done2, u2, um2); end
        tick();
    endtask

    initial begin
        test_reset();
        test_first_digit();
        test_sequence();
        test_stall();
        test_illegal_digit();
        test_flush_reset();
        test_radix2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule
